// File: rtl/ark_pkg.sv
// Shared defaults, types and helpers for the AddRoundKey stage.
package ark_pkg;

  localparam int DEF_DATA_W   = 128;
  localparam int DEF_NUM_KEYS = 15;
  localparam int DEF_TAG_W    = 4;
  localparam int DEF_KIDX_W   = (DEF_NUM_KEYS > 1) ? $clog2(DEF_NUM_KEYS) : 1;

  typedef logic [DEF_DATA_W-1:0] state_t;
  typedef logic [DEF_KIDX_W-1:0] kidx_t;

  typedef struct packed {
    state_t                 data;
    logic [DEF_TAG_W-1:0]   tag;
    logic                   err;
  } ark_beat_t;

  // Slot indices are unsigned; anything at or above the slot count is invalid.
  function automatic logic kidx_ok(input int unsigned idx, input int unsigned num_keys);
    return idx < num_keys;
  endfunction

endpackage

// File: rtl/add_round_key_unit_if.sv
// Streaming input/output bundle of the AddRoundKey stage.
interface add_round_key_unit_if #(
  parameter int DATA_W = 128,
  parameter int TAG_W  = 4,
  parameter int KIDX_W = 4
);
  // Valid/ready: a beat moves on a rising edge where valid && ready. A source
  // holds valid and payload stable until accepted; ready may depend on valid.
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [KIDX_W-1:0] in_key_idx;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              out_err;

  modport master (
    output in_valid, in_data, in_key_idx, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_data, in_key_idx, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_err
  );
endinterface

// File: rtl/add_round_key_unit_round_key_file.sv
// Round-key storage with per-slot loaded bits and a write-forwarding read port.
module round_key_file
  import ark_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_KEYS = DEF_NUM_KEYS,
  parameter int KIDX_W   = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [KIDX_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clear,
  input  logic [KIDX_W-1:0] raddr,
  output logic [DATA_W-1:0] rkey,
  output logic              rloaded
);

  logic [DATA_W-1:0]   keys [NUM_KEYS];
  logic [NUM_KEYS-1:0] loaded;
  logic                wr_ok;

  assign wr_ok = we && kidx_ok(32'(waddr), NUM_KEYS);

  // Clear drops every loaded bit; a same-cycle write re-marks its own slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_KEYS; i++) keys[i] <= '0;
      loaded <= '0;
    end else begin
      if (clear) loaded <= '0;
      if (wr_ok) begin
        keys[waddr]   <= wdata;
        loaded[waddr] <= 1'b1;
      end
    end
  end

  always_comb begin
    rkey    = '0;
    rloaded = 1'b0;
    if (wr_ok && (waddr == raddr)) begin
      rkey    = wdata;
      rloaded = 1'b1;
    end else if (kidx_ok(32'(raddr), NUM_KEYS)) begin
      rkey    = keys[raddr];
      rloaded = loaded[raddr] && !clear;
    end
  end

endmodule

// File: rtl/add_round_key_unit.sv
// Registered AddRoundKey stage: out = in ^ key[idx], one output register.
module add_round_key_unit
  import ark_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_KEYS = DEF_NUM_KEYS,
  parameter int TAG_W    = DEF_TAG_W,
  parameter int CNT_W    = 32,
  localparam int KIDX_W  = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_we,
  input  logic [KIDX_W-1:0] key_waddr,
  input  logic [DATA_W-1:0] key_wdata,
  input  logic              key_clear,
  add_round_key_unit_if.slave bus,
  output logic [CNT_W-1:0]  blk_count
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic              err;
  } beat_t;

  beat_t             beat_q;
  logic              valid_q;
  logic              accept;
  logic              drain;
  logic [DATA_W-1:0] key;
  logic              key_loaded;

  round_key_file #(
    .DATA_W   (DATA_W),
    .NUM_KEYS (NUM_KEYS),
    .KIDX_W   (KIDX_W)
  ) u_key_file (
    .clk     (clk),
    .rst     (rst),
    .we      (key_we),
    .waddr   (key_waddr),
    .wdata   (key_wdata),
    .clear   (key_clear),
    .raddr   (bus.in_key_idx),
    .rkey    (key),
    .rloaded (key_loaded)
  );

  // Single stage: accept whenever the register is empty or draining this cycle.
  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign drain        = valid_q && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      beat_q    <= '0;
      blk_count <= '0;
    end else begin
      if (accept) begin
        valid_q     <= 1'b1;
        beat_q.tag  <= bus.in_tag;
        beat_q.err  <= !key_loaded;
        // Blocks aimed at a missing key pass through unmodified but flagged.
        beat_q.data <= key_loaded ? (bus.in_data ^ key) : bus.in_data;
      end else if (bus.out_ready) begin
        valid_q <= 1'b0;
      end
      if (drain) blk_count <= blk_count + 1'b1;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = beat_q.data;
  assign bus.out_tag   = beat_q.tag;
  assign bus.out_err   = beat_q.err;

endmodule

// File: tb/tb_add_round_key_unit.sv
// Directed bench for add_round_key_unit with an in-order expected queue.
module tb_add_round_key_unit;
  import ark_pkg::*;

  localparam int DW = 128;
  localparam int TW = 4;
  localparam int KW = 4;
  localparam int CW = 32;
  localparam int W  = $bits(ark_beat_t);

  localparam logic [DW-1:0] KEY0  = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [DW-1:0] DIN0  = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [DW-1:0] DOUT0 = 128'h0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          key_we = 1'b0;
  logic [KW-1:0] key_waddr = '0;
  logic [DW-1:0] key_wdata = '0;
  logic          key_clear = 1'b0;
  logic [CW-1:0] blk_count;

  add_round_key_unit_if #(.DATA_W(DW), .TAG_W(TW), .KIDX_W(KW)) bus ();

  add_round_key_unit #(
    .DATA_W(DW), .NUM_KEYS(15), .TAG_W(TW), .CNT_W(CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_we    (key_we),
    .key_waddr (key_waddr),
    .key_wdata (key_wdata),
    .key_clear (key_clear),
    .bus       (bus.slave),
    .blk_count (blk_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks    = 0;
  int errors    = 0;
  int model_cnt = 0;
  logic [W-1:0] exp_q[$];
  ark_beat_t    mon_e;

  task automatic check(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    key_we = 1'b0;
    key_clear = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_key_idx = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    exp_q.delete();
    model_cnt = 0;
    #1 rst = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_key(input logic [KW-1:0] idx, input logic [DW-1:0] d);
    key_we = 1'b1;
    key_waddr = idx;
    key_wdata = d;
    @(posedge clk);
    #1 key_we = 1'b0;
  endtask

  task automatic send(input logic [KW-1:0] idx, input logic [DW-1:0] d, input logic [TW-1:0] t,
                      input logic [DW-1:0] exp_d, input logic exp_e);
    bit acc = 0;
    bus.in_valid = 1'b1;
    bus.in_key_idx = idx;
    bus.in_data = d;
    bus.in_tag = t;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (acc) begin
      exp_q.push_back({exp_d, t, exp_e});
      @(posedge clk);
      #1;
    end else begin
      check("send_timeout", DW'(bus.in_ready), DW'(1));
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 50; n++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain_q_empty", DW'(exp_q.size()), DW'(0));
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      model_cnt++;
      check("sb_q_nonempty", DW'(exp_q.size() != 0), DW'(1));
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("sb_data", bus.out_data, mon_e.data);
        check("sb_tag", DW'(bus.out_tag), DW'(mon_e.tag));
        check("sb_err", DW'(bus.out_err), DW'(mon_e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    check("rst_in_ready", DW'(bus.in_ready), DW'(1));
    check("rst_out_valid", DW'(bus.out_valid), DW'(0));
    check("rst_out_data", bus.out_data, '0);
    check("rst_out_tag", DW'(bus.out_tag), DW'(0));
    check("rst_out_err", DW'(bus.out_err), DW'(0));
    check("rst_blk_count", DW'(blk_count), DW'(0));

    // Unloaded slot and out-of-range index
    bus.out_ready = 1'b1;
    send(4'd5, {16{8'hAA}}, 4'd1, {16{8'hAA}}, 1'b1);
    check("unl_data", bus.out_data, {16{8'hAA}});
    check("unl_err", DW'(bus.out_err), DW'(1));
    send(4'd15, {16{8'h55}}, 4'd2, {16{8'h55}}, 1'b1);
    check("oor_err", DW'(bus.out_err), DW'(1));

    // Basic XOR, one-cycle latency
    write_key(4'd0, KEY0);
    send(4'd0, DIN0, 4'd3, DOUT0, 1'b0);
    check("basic_valid", DW'(bus.out_valid), DW'(1));
    check("basic_data", bus.out_data, DOUT0);
    check("basic_tag", DW'(bus.out_tag), DW'(3));
    check("basic_err", DW'(bus.out_err), DW'(0));
    wait_drain();

    // Backpressure over a four-block stream
    do_reset();
    write_key(4'd0, KEY0);
    write_key(4'd1, {16{8'h01}});
    write_key(4'd2, {16{8'h02}});
    write_key(4'd3, {16{8'h03}});
    bus.out_ready = 1'b1;
    fork
      begin
        send(4'd0, '0,           4'd0, KEY0,         1'b0);
        send(4'd1, {16{8'hF0}}, 4'd1, {16{8'hF1}}, 1'b0);
        send(4'd2, {16{8'h0F}}, 4'd2, {16{8'h0D}}, 1'b0);
        send(4'd3, {16{8'h30}}, 4'd3, {16{8'h33}}, 1'b0);
      end
      begin
        logic [DW-1:0] held;
        repeat (2) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        held = bus.out_data;
        check("bp_held_value", held, {16{8'hF1}});
        for (int k = 0; k < 3; k++) begin
          check("bp_in_ready", DW'(bus.in_ready), DW'(0));
          check("bp_out_valid", DW'(bus.out_valid), DW'(1));
          check("bp_stable", bus.out_data, held);
          if (k < 2) @(negedge clk);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    wait_drain();
    check("bp_blk_count", DW'(blk_count), DW'(4));

    // Write-to-read forwarding
    key_we = 1'b1; key_waddr = 4'd2; key_wdata = '1;
    bus.in_valid = 1'b1; bus.in_key_idx = 4'd2; bus.in_data = '0; bus.in_tag = 4'd5;
    @(negedge clk);
    check("fwd_in_ready", DW'(bus.in_ready), DW'(1));
    exp_q.push_back({{DW{1'b1}}, 4'd5, 1'b0});
    @(posedge clk);
    #1 key_we = 1'b0; bus.in_valid = 1'b0;
    check("fwd_data", bus.out_data, '1);
    check("fwd_err", DW'(bus.out_err), DW'(0));

    // Accept during a clear cycle sees its slot unloaded
    key_clear = 1'b1;
    send(4'd2, {16{8'hC3}}, 4'd6, {16{8'hC3}}, 1'b1);
    key_clear = 1'b0;
    check("clr_acc_err", DW'(bus.out_err), DW'(1));

    // Clear and write together: only the written slot survives
    key_clear = 1'b1; key_we = 1'b1; key_waddr = 4'd1; key_wdata = {16{8'h11}};
    @(posedge clk);
    #1 key_clear = 1'b0; key_we = 1'b0;
    send(4'd0, {16{8'h5A}}, 4'd7, {16{8'h5A}}, 1'b1);
    check("clrwe_idx0_err", DW'(bus.out_err), DW'(1));
    send(4'd1, '0, 4'd8, {16{8'h11}}, 1'b0);
    check("clrwe_idx1_data", bus.out_data, {16{8'h11}});
    wait_drain();

    // Asynchronous reset while an output is held
    bus.out_ready = 1'b0;
    send(4'd1, {16{8'h77}}, 4'd9, {16{8'h66}}, 1'b0);
    check("mid_valid_before", DW'(bus.out_valid), DW'(1));
    #2 rst = 1'b1;
    #1;
    check("mid_out_valid", DW'(bus.out_valid), DW'(0));
    check("mid_blk_count", DW'(blk_count), DW'(0));
    exp_q.delete();
    model_cnt = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    send(4'd0, {16{8'h77}}, 4'd10, {16{8'h77}}, 1'b1);
    check("post_rst_err", DW'(bus.out_err), DW'(1));
    wait_drain();
    check("final_blk_count", DW'(blk_count), DW'(model_cnt));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_round_key_unit.md
Name: add_round_key_unit

Overview:
- Parametrised, registered AddRoundKey stage with an internal round-key file and valid/ready streaming on both sides.
- Key expansion loads up to NUM_KEYS round keys. Each incoming state block names the key slot to apply, and the block returns state XOR key one cycle later.
- Sits between the key-schedule unit and the round datapath in the cipher core.
- Adds tag pass-through, a per-slot loaded check, a block counter and write-to-read key forwarding.

Parameters:
- DATA_W, 128, state/key width in bits; multiple of 8.
- NUM_KEYS, 15, number of round-key slots (covers AES-256: 14 rounds + 1).
- TAG_W, 4, width of the opaque tag carried alongside each block.
- CNT_W, 32, width of the processed-block counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_we  in  1  write strobe for the key file.
- key_waddr  in  $clog2(NUM_KEYS)  slot index to write.
- key_wdata  in  DATA_W  round key value.
- key_clear  in  1  one-cycle pulse; invalidates all slots.
- in_valid  in  1  input block valid.
- in_ready  out  1  unit can accept the input block.
- in_data  in  DATA_W  state block.
- in_key_idx  in  $clog2(NUM_KEYS)  key slot to apply.
- in_tag  in  TAG_W  opaque tag.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DATA_W  in_data XOR selected key.
- out_tag  out  TAG_W  tag of the result.
- out_err  out  1  selected slot was not loaded, or index >= NUM_KEYS.
- blk_count  out  CNT_W  number of completed output handshakes.

Behaviour:
- Reset (async assert, sync release): key file contents zeroed, loaded bitmap 0, out_valid 0, out_data 0, out_tag 0, out_err 0, blk_count 0. in_ready is 1 once rst deasserts.
- Accept condition: in_valid && in_ready. in_ready = !out_valid || out_ready (single output register, full throughput, combinational ready path).
- On accept:
  - out_data <= in_data ^ key[in_key_idx]
  - out_tag <= in_tag
  - out_err <= !loaded[in_key_idx] || (in_key_idx >= NUM_KEYS)
  - out_valid <= 1
  - Latency is exactly 1 cycle.
- Error case: when out_err would be 1, out_data <= in_data (no XOR). The block is still delivered in order; it is never dropped.
- Output hold: when out_valid && !out_ready, out_data, out_tag and out_err stay stable, and no input is accepted.
- Output drain: when out_valid && out_ready and no new accept, out_valid <= 0.
- blk_count increments on each out_valid && out_ready and wraps modulo 2^CNT_W.
- Key write: key_we stores key_wdata to slot key_waddr and sets loaded[key_waddr]. Writes with key_waddr >= NUM_KEYS are ignored.
- Forwarding: if key_we and an accept occur in the same cycle with key_waddr == in_key_idx, the NEW key_wdata is applied and out_err = 0.
- key_clear clears the loaded bitmap only; key contents are kept. If key_clear and key_we occur in the same cycle, the write wins for its slot (slot loaded, all others cleared). An accept in a key_clear cycle sees its slot as unloaded, unless the forwarding case applies.
- No state machine beyond the output-valid flag. The key file is independent of the stream and may be rewritten while blocks are in flight; an already-registered result is unaffected.
- rst asserted mid-transfer: the pending output is discarded immediately (out_valid 0) and all keys are invalidated.

Decomposition:
- ark_pkg:
  - localparams: default DATA_W, NUM_KEYS, KIDX_W = $clog2(NUM_KEYS).
  - typedef state_t (logic [DATA_W-1:0]).
  - typedef kidx_t.
  - struct ark_beat_t {state_t data; logic [TAG_W-1:0] tag; logic err;}.
- Sub-module round_key_file:
  - NUM_KEYS x DATA_W flop array plus loaded bitmap, write port, clear.
  - One combinational read port returning key and loaded, with the write-forward mux inside.
- Top: the handshake register, XOR, error logic and counter.

Test Plan:
- Basic XOR: load slot 0 = 0F0E0D0C0B0A09080706050403020100; send 00112233445566778899AABBCCDDEEFF, idx 0, tag 3. Expect 1 cycle later: out_data 0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFFF, tag 3, err 0.
- Unloaded slot: after reset, send data AA..AA to idx 5. Expect out_data AA..AA, err 1. Then send idx 15 (>= NUM_KEYS). Expect err 1.
- Backpressure: stream 4 blocks (idx 0..3, tags 0..3) with out_ready low for 3 cycles mid-stream. Expect in_ready low while out_valid is held, output stable, all 4 delivered in order, blk_count = 4.
- Forwarding: in one cycle, key_we slot 2 = FF..FF and accept idx 2 with data 00..00. Expect out_data FF..FF, err 0.
- key_clear and key_we in the same cycle (slot 1 = 11..11): then idx 0 gives err 1; idx 1 with data 00..00 gives 11..11, err 0.
- Async reset mid-stream: assert rst while out_valid = 1 and out_ready = 0. Expect out_valid 0 immediately, blk_count 0, and subsequent idx 0 gives err 1.
